tia_horizontal_timing: RTL

- Horizontal line sequencer for the TIA core; drives the set/reset F1 flops that generate HSYNC, HBLANK, colour burst and RDY (WSYNC).
- Divides the colour clock by 4 into a 57-state horizontal count, giving a 228-colour-clock line.
- Decodes fixed count values into set/clear events.
- Services the RSYNC, WSYNC and HMOVE register strobes from the bus decoder.

---
 rtl/tia_horizontal_timing_if.sv | 23 ++
 rtl/tia_horizontal_timing.sv | 127 ++++++++++++
 2 files changed

// File: rtl/tia_horizontal_timing_if.sv
// Strobe and status bundle between the bus decoder and the horizontal line sequencer.
interface tia_horizontal_timing_if;
    logic       rsync;
    logic       wsync;
    logic       hmove;
    logic [5:0] hcount;
    logic [1:0] phase;
    logic       hsync;
    logic       hblank;
    logic       cb;
    logic       rdy;
    logic       line_start;

    modport master (
        output rsync, wsync, hmove,
        input  hcount, phase, hsync, hblank, cb, rdy, line_start
    );

    modport slave (
        input  rsync, wsync, hmove,
        output hcount, phase, hsync, hblank, cb, rdy, line_start
    );
endinterface

// File: rtl/tia_horizontal_timing.sv
// TIA horizontal line sequencer: colour clock / 4 prescaler, 57-count line,
// and the count-decoded set/clear events for HSYNC, HBLANK, colour burst and RDY.
module tia_horizontal_timing #(
    parameter int LINE_COUNTS     = 57,
    parameter int PRESCALE        = 4,
    parameter int HSYNC_SET       = 4,
    parameter int HSYNC_CLR       = 8,
    parameter int CB_CLR          = 12,
    parameter int HBLANK_CLR      = 17,
    parameter int HBLANK_LATE_CLR = 19
) (
    input logic                   clock,
    input logic                   reset,
    tia_horizontal_timing_if.slave bus
);

    localparam logic [1:0] PH_LAST  = 2'(PRESCALE - 1);
    localparam logic [5:0] CNT_LAST = 6'(LINE_COUNTS - 1);
    localparam logic [5:0] C_HS_SET = 6'(HSYNC_SET);
    localparam logic [5:0] C_HS_CLR = 6'(HSYNC_CLR);
    localparam logic [5:0] C_CB_CLR = 6'(CB_CLR);
    localparam logic [5:0] C_HB_CLR = 6'(HBLANK_CLR);
    localparam logic [5:0] C_HB_LATE = 6'(HBLANK_LATE_CLR);

    logic [1:0] phase_q, phase_d;
    logic [5:0] hcount_q, hcount_d;
    logic       hsync_q, hsync_d;
    logic       hblank_q, hblank_d;
    logic       cb_q, cb_d;
    logic       rdy_q, rdy_d;
    logic       line_start_q, line_start_d;
    logic       hmove_latch_q, hmove_latch_d;
    logic       enter;
    logic       enter_zero;

    always_comb begin
        phase_d  = phase_q + 2'd1;
        hcount_d = hcount_q;
        enter    = 1'b0;
        if (phase_q == PH_LAST) begin
            phase_d  = 2'd0;
            hcount_d = (hcount_q == CNT_LAST) ? 6'd0 : hcount_q + 6'd1;
            enter    = 1'b1;
        end
        // rsync restarts the line and overrides the normal advance
        if (bus.rsync) begin
            phase_d  = 2'd0;
            hcount_d = 6'd0;
            enter    = 1'b1;
        end
        enter_zero = enter && (hcount_d == 6'd0);
    end

    always_comb begin
        hsync_d       = hsync_q;
        hblank_d      = hblank_q;
        cb_d          = cb_q;
        rdy_d         = rdy_q;
        hmove_latch_d = hmove_latch_q;
        line_start_d  = enter_zero;

        if (bus.wsync) begin
            rdy_d = 1'b0;
        end

        if (enter_zero) begin
            hblank_d = 1'b1;
            hsync_d  = 1'b0;
            cb_d     = 1'b0;
            rdy_d    = 1'b1;
        end else if (enter) begin
            if (hcount_d == C_HS_SET) begin
                hsync_d = 1'b1;
            end
            if (hcount_d == C_HS_CLR) begin
                hsync_d = 1'b0;
                cb_d    = 1'b1;
            end
            if (hcount_d == C_CB_CLR) begin
                cb_d = 1'b0;
            end
            if (hcount_d == C_HB_CLR && !hmove_latch_q) begin
                hblank_d = 1'b0;
            end
            if (hcount_d == C_HB_LATE && hmove_latch_q) begin
                hblank_d      = 1'b0;
                hmove_latch_d = 1'b0;
            end
        end

        // A fresh strobe wins over the late-clear consuming the latch
        if (bus.hmove) begin
            hmove_latch_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_q       <= 2'd0;
            hcount_q      <= 6'd0;
            hsync_q       <= 1'b0;
            hblank_q      <= 1'b1;
            cb_q          <= 1'b0;
            rdy_q         <= 1'b1;
            line_start_q  <= 1'b0;
            hmove_latch_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            hcount_q      <= hcount_d;
            hsync_q       <= hsync_d;
            hblank_q      <= hblank_d;
            cb_q          <= cb_d;
            rdy_q         <= rdy_d;
            line_start_q  <= line_start_d;
            hmove_latch_q <= hmove_latch_d;
        end
    end

    assign bus.phase      = phase_q;
    assign bus.hcount     = hcount_q;
    assign bus.hsync      = hsync_q;
    assign bus.hblank     = hblank_q;
    assign bus.cb         = cb_q;
    assign bus.rdy        = rdy_q;
    assign bus.line_start = line_start_q;

endmodule
